// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative write-back data cache controller.
// Holds the controller state encoding, line/address geometry and a word-select helper.
package dcache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_W     = 256;
  localparam int unsigned OFFSET_W   = 5;
  localparam int unsigned WORD_SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WB_REQ  = 2'd1,
    RF_REQ  = 2'd2,
    RF_WAIT = 2'd3
  } state_e;

  // Extract one 32-bit word from a 256-bit line.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0]     line,
                                                 input logic [WORD_SEL_W-1:0] sel);
    return line[{sel, 5'b0} +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_lru.sv
// Per-set LRU age tracking and victim selection.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset (clears all ages)
//   upd_i         record an access (hit or fill) to way_i of set set_i
//   set_i         set being looked up / updated
//   way_i         accessed way
//   valid_i       valid bits of the ways in set_i
//   victim_c      combinational victim: lowest invalid way, else the oldest way
module dcache_lru #(
  parameter int unsigned WAYS = 2,
  parameter int unsigned SETS = 16,
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int unsigned SET_W = $clog2(SETS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             upd_i,
  input  logic [SET_W-1:0] set_i,
  input  logic [WAY_W-1:0] way_i,
  input  logic [WAYS-1:0]  valid_i,
  output logic [WAY_W-1:0] victim_c
);

  if (WAYS == 1) begin : g_direct
    // Direct-mapped: only one candidate, no age state.
    assign victim_c = '0;
    logic unused_c;
    assign unused_c = ^{clk_i, rst_i, upd_i, set_i, way_i, valid_i};
  end else begin : g_lru
    localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] prev_age_c;

    // A way being filled from invalid counts as oldest, so ages stay a permutation.
    always_comb begin
      prev_age_c = valid_i[way_i] ? age_q[set_i][way_i] : AGE_MAX;
    end

    // Age update: accessed way becomes youngest, younger ways age by one.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) begin
            age_q[s][w] <= '0;
          end
        end
      end else if (upd_i) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == way_i) begin
            age_q[set_i][w] <= '0;
          end else if (age_q[set_i][w] < prev_age_c) begin
            age_q[set_i][w] <= age_q[set_i][w] + WAY_W'(1);
          end
        end
      end
    end

    // Victim: oldest way, overridden by the lowest-index invalid way.
    always_comb begin
      victim_c = '0;
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[set_i][w] == AGE_MAX) victim_c = WAY_W'(w);
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (!valid_i[w]) victim_c = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/dcache_assoc_ctrl.sv
// Set-associative, write-back, write-allocate data cache controller with LRU replacement.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   cpu_addr_i/cpu_data_i            CPU byte address (word aligned) and store data
//   cpu_MemRead_i/cpu_MemWrite_i     load / store request (both high = store)
//   cpu_data_o, cpu_stall_o          load data (0 unless hitting), pipeline freeze
//   mem_data_i, mem_ack_i            refill line and one-cycle completion pulse
//   mem_data_o, mem_addr_o           write-back line, line-aligned memory address
//   mem_enable_o, mem_write_o        memory request, 1 = write-back / 0 = refill
module dcache_assoc_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS = 2,
  parameter int unsigned SETS = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [31:0]       mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - OFFSET_W - IDX_W;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e state_q, state_d;

  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   dirty_q [WAYS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [LINE_W-1:0] data_q  [WAYS][SETS];

  logic [IDX_W-1:0]      idx_c;
  logic [TAG_W-1:0]      tag_c;
  logic [WORD_SEL_W-1:0] word_c;
  logic                  req_c, store_c;
  logic                  hit_any_c, hit_c, miss_c, fill_c;
  logic [WAY_W-1:0]      hit_way_c;
  logic [LINE_W-1:0]     hit_line_c;

  logic [WAY_W-1:0]  victim_c, victim_q;
  logic              victim_dirty_c;
  logic [TAG_W-1:0]  miss_tag_q;
  logic [IDX_W-1:0]  miss_idx_q;
  logic [TAG_W-1:0]  victim_tag_c;
  logic [LINE_W-1:0] victim_line_c;

  logic [IDX_W-1:0] lru_set_c;
  logic [WAY_W-1:0] lru_way_c;
  logic [WAYS-1:0]  set_valid_c;
  logic             lru_upd_c;

  logic unused_c;
  assign unused_c = ^cpu_addr_i[1:0];

  // Address split and request decode.
  assign idx_c   = cpu_addr_i[OFFSET_W +: IDX_W];
  assign tag_c   = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign word_c  = cpu_addr_i[2 +: WORD_SEL_W];
  assign req_c   = cpu_MemRead_i | cpu_MemWrite_i;
  assign store_c = cpu_MemWrite_i;

  // Tag compare across all ways.
  always_comb begin
    hit_any_c = 1'b0;
    hit_way_c = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx_c] && (tag_q[w][idx_c] == tag_c)) begin
        hit_any_c = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    end
  end

  // Lookups only count in IDLE, so a freshly filled line is returned once back in IDLE.
  assign hit_c      = req_c && (state_q == IDLE) && hit_any_c;
  assign miss_c     = req_c && (state_q == IDLE) && !hit_any_c;
  assign fill_c     = (state_q == RF_REQ) && mem_ack_i;
  assign hit_line_c = data_q[hit_way_c][idx_c];

  // Replacement bookkeeping: use the latched miss set while a transfer is in flight.
  assign lru_set_c = (state_q == IDLE) ? idx_c : miss_idx_q;
  assign lru_way_c = fill_c ? victim_q : hit_way_c;
  assign lru_upd_c = hit_c | fill_c;

  always_comb begin
    set_valid_c = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_valid_c[w] = valid_q[w][lru_set_c];
    end
  end

  dcache_lru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .upd_i    (lru_upd_c),
    .set_i    (lru_set_c),
    .way_i    (lru_way_c),
    .valid_i  (set_valid_c),
    .victim_c (victim_c)
  );

  assign victim_dirty_c = valid_q[victim_c][idx_c] && dirty_q[victim_c][idx_c];
  assign victim_tag_c   = tag_q[victim_q][miss_idx_q];
  assign victim_line_c  = data_q[victim_q][miss_idx_q];

  // Latch the miss context so memory address and victim stay fixed during the transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      victim_q   <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else if (miss_c) begin
      victim_q   <= victim_c;
      miss_tag_q <= tag_c;
      miss_idx_q <= idx_c;
    end
  end

  // Valid/dirty state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else if (fill_c) begin
      valid_q[victim_q][miss_idx_q] <= 1'b1;
      dirty_q[victim_q][miss_idx_q] <= 1'b0;
    end else if (hit_c && store_c) begin
      dirty_q[hit_way_c][idx_c] <= 1'b1;
    end
  end

  // Tag and line storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (fill_c) begin
      tag_q[victim_q][miss_idx_q]  <= miss_tag_q;
      data_q[victim_q][miss_idx_q] <= mem_data_i;
    end else if (hit_c && store_c) begin
      data_q[hit_way_c][idx_c][{word_c, 5'b0} +: WORD_W] <= cpu_data_i;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_c) state_d = victim_dirty_c ? WB_REQ : RF_REQ;
      WB_REQ:  if (mem_ack_i) state_d = RF_REQ;
      RF_REQ:  if (mem_ack_i) state_d = RF_WAIT;
      RF_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    cpu_stall_o  = req_c && !hit_c;
    cpu_data_o   = hit_c ? line_word(hit_line_c, word_c) : '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      WB_REQ: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {victim_tag_c, miss_idx_q, OFFSET_W'(0)};
        mem_data_o   = victim_line_c;
      end
      RF_REQ: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {miss_tag_q, miss_idx_q, OFFSET_W'(0)};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_assoc_ctrl.sv
// Scoreboard bench for dcache_assoc_ctrl (WAYS=2, SETS=16): a backing-memory model answers
// refills and absorbs write-backs; expected load data and memory requests are queued when
// each access is issued and compared when the cache produces them.
module tb_dcache_assoc_ctrl;

  localparam int unsigned LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_rd, cpu_wr, stall;
  logic [LW-1:0] mem_rdata, mem_wdata;
  logic          mem_ack, mem_en, mem_we;
  logic [31:0]   mem_addr;

  always #5 clk = ~clk;

  dcache_assoc_ctrl #(.WAYS(2), .SETS(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cpu_addr_i     (cpu_addr),
    .cpu_data_i     (cpu_wdata),
    .cpu_MemRead_i  (cpu_rd),
    .cpu_MemWrite_i (cpu_wr),
    .cpu_data_o     (cpu_rdata),
    .cpu_stall_o    (stall),
    .mem_data_i     (mem_rdata),
    .mem_ack_i      (mem_ack),
    .mem_data_o     (mem_wdata),
    .mem_addr_o     (mem_addr),
    .mem_enable_o   (mem_en),
    .mem_write_o    (mem_we)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] w0;
  } mem_exp_t;

  mem_exp_t      mem_q[$];
  logic [31:0]   rd_q[$];
  logic [LW-1:0] line_mem [logic [31:0]];
  logic [31:0]   ref_mem  [logic [31:0]];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] get_line(input logic [31:0] la);
    logic [LW-1:0] l;
    if (line_mem.exists(la)) return line_mem[la];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = {la[15:0], 16'hC0D0 + 16'(i)};
    return l;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [LW-1:0] l;
    if (ref_mem.exists(a)) return ref_mem[a];
    l = get_line({a[31:5], 5'b0});
    return l[{a[4:2], 5'b0} +: 32];
  endfunction

  task automatic push_mem(input logic wr, input logic [31:0] addr);
    mem_exp_t e;
    e.wr   = wr;
    e.addr = addr;
    e.w0   = wr ? exp_word(addr) : 32'h0;
    mem_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_mem.delete();
  endtask

  // Issue one access, act as memory while stalled, then score the result.
  task automatic access(input logic [31:0] a, input logic [31:0] d,
                        input logic rd, input logic wr, input logic exp_hit);
    int n, ack_n, wait_n;
    logic in_xfer, done;
    logic [31:0] xfer_addr, exp_d;
    mem_exp_t e;
    @(negedge clk);
    cpu_addr = a; cpu_wdata = d; cpu_rd = rd; cpu_wr = wr;
    if (wr) ref_mem[a] = d;
    else    rd_q.push_back(exp_word(a));
    n = 0; ack_n = -1; wait_n = 0; in_xfer = 1'b0; done = 1'b0; xfer_addr = '0;
    #1;
    chk("stall_first_cycle", 32'(stall), 32'(!exp_hit));
    if (!exp_hit) chk("data_zero_on_miss", cpu_rdata, 32'h0);
    while (!done && n < 200) begin
      if (!stall) begin
        done = 1'b1;
      end else if (mem_en) begin
        if (!in_xfer) begin
          in_xfer = 1'b1; wait_n = 0; xfer_addr = mem_addr;
          if (mem_q.size() == 0) begin
            chk("unexpected_mem_req", mem_addr, 32'hFFFF_FFFF);
          end else begin
            e = mem_q.pop_front();
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_write", 32'(mem_we), 32'(e.wr));
            if (e.wr) chk("wb_word0", mem_wdata[31:0], e.w0);
          end
        end
        wait_n++;
        if (wait_n == 3) begin
          chk("mem_addr_stable", mem_addr, xfer_addr);
          if (mem_we) line_mem[xfer_addr] = mem_wdata;
          else        mem_rdata = get_line(xfer_addr);
          mem_ack = 1'b1; in_xfer = 1'b0; ack_n = n;
        end
      end
      if (!done) begin
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        n++;
      end
    end
    if (!done)           chk("access_timeout", 32'(n), 32'h0);
    else if (ack_n >= 0) chk("fill_to_hit_cycles", 32'(n - ack_n), 32'd2);
    if (!wr) begin
      exp_d = rd_q.pop_front();
      if (done) chk("load_data", cpu_rdata, exp_d);
    end
    chk("mem_reqs_consumed", 32'(mem_q.size()), 32'h0);
    @(negedge clk);
    cpu_rd = 1'b0; cpu_wr = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    mem_rdata = '0; mem_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [LW-1:0] l;
      l = (i == 0) ? '0 : line_mem[32'h40];
      l[i*32 +: 32] = 32'(i + 1) * 32'h1111_1111;
      line_mem[32'h40] = l;
    end

    do_reset();
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_cpu_data", cpu_rdata, 32'h0);

    // Cold load, then a same-line hit.
    push_mem(1'b0, 32'h40);
    access(32'h40, 32'h0, 1'b1, 1'b0, 1'b0);
    access(32'h44, 32'h0, 1'b1, 1'b0, 1'b1);

    // Dirty eviction: store hit, fill other way, conflicting load forces write-back.
    access(32'h40, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);
    push_mem(1'b0, 32'h240);
    access(32'h240, 32'h0, 1'b1, 1'b0, 1'b0);
    push_mem(1'b1, 32'h40);
    push_mem(1'b0, 32'h440);
    access(32'h440, 32'h0, 1'b1, 1'b0, 1'b0);
    push_mem(1'b0, 32'h40);
    access(32'h40, 32'h0, 1'b1, 1'b0, 1'b0);

    // LRU ordering from a clean cache.
    do_reset();
    push_mem(1'b0, 32'h40);
    access(32'h40, 32'h0, 1'b1, 1'b0, 1'b0);
    push_mem(1'b0, 32'h240);
    access(32'h240, 32'h0, 1'b1, 1'b0, 1'b0);
    access(32'h40, 32'h0, 1'b1, 1'b0, 1'b1);
    push_mem(1'b0, 32'h440);
    access(32'h440, 32'h0, 1'b1, 1'b0, 1'b0);
    access(32'h40, 32'h0, 1'b1, 1'b0, 1'b1);
    push_mem(1'b0, 32'h240);
    access(32'h240, 32'h0, 1'b1, 1'b0, 1'b0);

    // Read and write both high behaves as a store.
    push_mem(1'b0, 32'h80);
    access(32'h80, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b0);
    access(32'h80, 32'h0, 1'b1, 1'b0, 1'b1);

    // Reset while a write-back is outstanding.
    push_mem(1'b0, 32'h280);
    access(32'h280, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    cpu_addr = 32'h480; cpu_rd = 1'b1;
    #1;
    n = 0;
    while (!(mem_en && mem_we) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("wb_started", 32'(mem_en & mem_we), 32'h1);
    chk("wb_addr_before_rst", mem_addr, 32'h80);
    rst = 1'b1; cpu_rd = 1'b0;
    @(negedge clk); #1;
    chk("rst_in_wb_mem_en", 32'(mem_en), 32'h0);
    chk("rst_in_wb_stall", 32'(stall), 32'h0);
    chk("rst_in_wb_mem_we", 32'(mem_we), 32'h0);
    rst = 1'b0;
    ref_mem.delete();
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("late_ack_mem_en", 32'(mem_en), 32'h0);
    chk("late_ack_stall", 32'(stall), 32'h0);
    push_mem(1'b0, 32'h40);
    access(32'h40, 32'h0, 1'b1, 1'b0, 1'b0);
    push_mem(1'b0, 32'h80);
    access(32'h80, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/dcache_assoc_ctrl.md
DCACHE_ASSOC_CTRL -- requirements
Module: dcache_assoc_ctrl

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity (1, 2 or 4).
REQ-002 SHALL have parameter SETS, default 16, set count (power of two, 2..256).
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port cpu_addr_i, input, 32, byte address (word-aligned).
REQ-006 SHALL have port cpu_data_i, input, 32, store data.
REQ-007 SHALL have port cpu_MemRead_i, input, 1, load request.
REQ-008 SHALL have port cpu_MemWrite_i, input, 1, store request.
REQ-009 SHALL have port cpu_data_o, output, 32, load data.
REQ-010 SHALL have port cpu_stall_o, output, 1, pipeline freeze.
REQ-011 SHALL have port mem_data_i, input, 256, refill line.
REQ-012 SHALL have port mem_ack_i, input, 1, one-cycle completion pulse.
REQ-013 SHALL have port mem_data_o, output, 256, write-back line.
REQ-014 SHALL have port mem_addr_o, output, 32, line-aligned memory address.
REQ-015 SHALL have port mem_enable_o, output, 1, memory request.
REQ-016 SHALL have port mem_write_o, output, 1, 1 = write-back, 0 = refill.

Function
REQ-017 SHALL split the address into offset [4:0], word [4:2], index [4+log2(SETS):5] and tag (remaining upper bits); there SHALL be 32-byte lines.
REQ-018 SHALL treat a request as active when cpu_MemRead_i or cpu_MemWrite_i is 1; both high SHALL be treated as a store.
REQ-019 SHALL detect a hit combinationally (valid and tag match in any way); on a hit cpu_stall_o SHALL be 0 in the same cycle and cpu_data_o SHALL be the selected word.
REQ-020 SHALL, on a store hit, update the word and set that way's dirty bit at the clock edge.
REQ-021 SHALL, on a miss, drive cpu_stall_o to 1 combinationally from the request cycle until the cycle in which the access hits.
REQ-022 SHALL use FSM states IDLE, WB_REQ, RF_REQ, RF_WAIT; IDLE->WB_REQ on a miss with a dirty victim, IDLE->RF_REQ on a miss with a clean or invalid victim, WB_REQ->RF_REQ on mem_ack_i, RF_REQ->RF_WAIT on mem_ack_i (line written: valid=1, dirty=0, new tag), RF_WAIT->IDLE unconditionally, after which the re-lookup hits.
REQ-023 SHALL hold mem_enable_o=1 together with a stable address, data and mem_write_o throughout WB_REQ and RF_REQ, and hold mem_enable_o=0 otherwise.
REQ-024 SHALL drive mem_addr_o with {victim tag, index, 5'b0} in WB_REQ and {request tag, index, 5'b0} in RF_REQ.
REQ-025 SHALL ignore mem_ack_i outside WB_REQ and RF_REQ.
REQ-026 SHALL choose the victim as the lowest-index invalid way; when no way is invalid, it SHALL choose the way whose LRU age equals WAYS-1.
REQ-027 SHALL keep a log2(WAYS)-bit age per way per set; on a hit or fill the accessed way SHALL become 0, and every way younger than its previous age SHALL increment by 1.
REQ-028 SHALL, when WAYS=1, make the victim way 0 and hold no LRU state.
REQ-029 SHALL make cpu_data_o 0 whenever no hit is being returned.

Reset
REQ-030 SHALL, when rst_i=1, clear all valid, dirty and age state, go to IDLE, and drive mem_enable_o=0, mem_write_o=0 and cpu_stall_o=0 from the following cycle.
REQ-031 SHALL, on reset during WB_REQ or RF_REQ, abandon the transfer without write-back; a late mem_ack_i SHALL be ignored.

Structure
REQ-032 SHALL place the state enum, LINE_W=256, OFFSET_W=5 and WORD_SEL_W=3 in the shared package dcache_pkg.
REQ-033 SHALL implement the per-set age update and victim selection in the sub-module dcache_lru.

Verification (WAYS=2, SETS=16)
REQ-034 SHALL cover a cold load of 0x40: stall=1, mem_addr_o=0x40, mem_write_o=0; ack with line word0=0x11111111 -> stall drops two cycles later, cpu_data_o=0x11111111.
REQ-035 SHALL cover a load of 0x44 after that fill: stall=0 in the same cycle, cpu_data_o=line word1.
REQ-036 SHALL cover a store of 0xDEADBEEF to 0x40, fill 0x240, then load 0x440: write-back at mem_addr_o=0x40 with mem_write_o=1 and mem_data_o[31:0]=0xDEADBEEF, then refill at 0x440.
REQ-037 SHALL cover LRU: load 0x40, 0x240, 0x40, then 0x440 -> no write-back; 0x240 evicted; a later 0x40 hits.
REQ-038 SHALL cover reset asserted in WB_REQ: next cycle mem_enable_o=0 and stall=0; a later ack is ignored; a load of 0x40 misses.
REQ-039 SHALL cover read and write both high to 0x80 with data 0xA5A5A5A5 -> treated as a store; a subsequent load of 0x80 returns 0xA5A5A5A5.
